battleship_shot_controller: RTL and testbench

Attacker-side initiator for the 5x5 Battleship board. It moves a targeting cursor from debounced button pulses and issues single-cycle shoot requests with row/column to the board. It reads back the targeted cell's state, tallies hits and shots, blocks duplicate shots, and flags game over when every ship cell is hit. It sits between the button/debounce front end and the board register, and drives the board's shoot, shootRow and shootCol inputs.

---
 rtl/battleship_shot_if.sv | 31 +++
 rtl/battleship_shot_controller.sv | 171 +++++++++++++++++
 tb/tb_battleship_shot_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/battleship_shot_if.sv
// Attacker-side bus between the button front end / board and the shot controller.
interface battleship_shot_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_fire;
  logic [1:0] cell_state;
  logic       shoot;
  logic [3:0] shootRow;
  logic [3:0] shootCol;
  logic [4:0] hit_count;
  logic [4:0] shot_count;
  logic [1:0] last_result;
  logic       dup_shot;
  logic       resp_error;
  logic       busy;
  logic       game_over;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, btn_fire, cell_state,
    output shoot, shootRow, shootCol, hit_count, shot_count, last_result,
           dup_shot, resp_error, busy, game_over
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, btn_fire, cell_state,
    input  shoot, shootRow, shootCol, hit_count, shot_count, last_result,
           dup_shot, resp_error, busy, game_over
  );
endinterface

// File: rtl/battleship_shot_controller.sv
// Cursor-driven shot initiator: moves the target, fires once per cell, tallies
// board responses and flags game over once every ship cell has been hit.
module battleship_shot_controller #(
  parameter int unsigned ROWS         = 5,
  parameter int unsigned COLS         = 5,
  parameter int unsigned SHIP_CELLS   = 5,
  parameter int unsigned RESP_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  battleship_shot_if.master bus
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned POS_W = 4;
  localparam int unsigned TMO_W = $clog2(RESP_TIMEOUT + 1);

  localparam logic [1:0] CELL_MISS = 2'd2;
  localparam logic [1:0] CELL_HIT  = 2'd3;
  localparam logic [1:0] RES_NONE  = 2'd0;

  typedef enum logic [1:0] {
    S_SELECT = 2'd0,
    S_FIRE   = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state,    w_state;
  logic [ROW_W-1:0]   r_row,      w_row;
  logic [COL_W-1:0]   r_col,      w_col;
  logic [CELLS-1:0]   r_map,      w_map;
  logic [TMO_W-1:0]   r_tmo,      w_tmo;
  logic [CNT_W-1:0]   r_hit_cnt,  w_hit_cnt;
  logic [CNT_W-1:0]   r_shot_cnt, w_shot_cnt;
  logic [1:0]         r_last,     w_last;
  logic               r_shoot,    w_shoot;
  logic               r_dup,      w_dup;
  logic               r_err,      w_err;
  logic               r_busy,     w_busy;
  logic               r_over,     w_over;
  logic [IDX_W-1:0]   w_idx;
  logic [CNT_W-1:0]   w_hit_inc;
  logic [CNT_W-1:0]   w_shot_inc;

  assign w_idx      = IDX_W'(r_row) * IDX_W'(COLS) + IDX_W'(r_col);
  assign w_hit_inc  = (r_hit_cnt  == CNT_W'(CELLS)) ? r_hit_cnt  : r_hit_cnt  + CNT_W'(1);
  assign w_shot_inc = (r_shot_cnt == CNT_W'(CELLS)) ? r_shot_cnt : r_shot_cnt + CNT_W'(1);

  // Next-state and next-output logic; every registered output is decided here.
  always_comb begin
    w_state    = r_state;
    w_row      = r_row;
    w_col      = r_col;
    w_map      = r_map;
    w_tmo      = r_tmo;
    w_hit_cnt  = r_hit_cnt;
    w_shot_cnt = r_shot_cnt;
    w_last     = r_last;
    w_err      = r_err;
    w_shoot    = 1'b0;
    w_dup      = 1'b0;

    unique case (r_state)
      S_SELECT: begin
        if (bus.btn_fire) begin
          if (r_map[w_idx]) begin
            w_dup = 1'b1;
          end else begin
            w_state = S_FIRE;
            w_shoot = 1'b1;
          end
        end else if (bus.btn_up) begin
          w_row = (r_row == '0) ? ROW_W'(ROWS - 1) : r_row - ROW_W'(1);
        end else if (bus.btn_down) begin
          w_row = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
        end else if (bus.btn_left) begin
          w_col = (r_col == '0) ? COL_W'(COLS - 1) : r_col - COL_W'(1);
        end else if (bus.btn_right) begin
          w_col = (r_col == COL_W'(COLS - 1)) ? '0 : r_col + COL_W'(1);
        end
      end

      S_FIRE: begin
        w_state = S_WAIT;
        w_tmo   = '0;
      end

      S_WAIT: begin
        if (bus.cell_state == CELL_MISS) begin
          w_map[w_idx] = 1'b1;
          w_shot_cnt   = w_shot_inc;
          w_last       = CELL_MISS;
          w_state      = S_SELECT;
        end else if (bus.cell_state == CELL_HIT) begin
          w_map[w_idx] = 1'b1;
          w_shot_cnt   = w_shot_inc;
          w_hit_cnt    = w_hit_inc;
          w_last       = CELL_HIT;
          w_state      = (w_hit_inc == CNT_W'(SHIP_CELLS)) ? S_DONE : S_SELECT;
        end else if (r_tmo == TMO_W'(RESP_TIMEOUT - 1)) begin
          // Board never answered: give up on this shot without marking the cell.
          w_err   = 1'b1;
          w_tmo   = '0;
          w_state = S_SELECT;
        end else begin
          w_tmo = r_tmo + TMO_W'(1);
        end
      end

      S_DONE: begin
        w_state = S_DONE;
      end

      default: begin
        w_state = S_SELECT;
      end
    endcase

    w_busy = (w_state == S_FIRE) || (w_state == S_WAIT);
    w_over = r_over || (w_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_SELECT;
      r_row      <= '0;
      r_col      <= '0;
      r_map      <= '0;
      r_tmo      <= '0;
      r_hit_cnt  <= '0;
      r_shot_cnt <= '0;
      r_last     <= RES_NONE;
      r_shoot    <= 1'b0;
      r_dup      <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_row      <= w_row;
      r_col      <= w_col;
      r_map      <= w_map;
      r_tmo      <= w_tmo;
      r_hit_cnt  <= w_hit_cnt;
      r_shot_cnt <= w_shot_cnt;
      r_last     <= w_last;
      r_shoot    <= w_shoot;
      r_dup      <= w_dup;
      r_err      <= w_err;
      r_busy     <= w_busy;
      r_over     <= w_over;
    end
  end

  assign bus.shoot       = r_shoot;
  assign bus.shootRow    = POS_W'(r_row);
  assign bus.shootCol    = POS_W'(r_col);
  assign bus.hit_count   = r_hit_cnt;
  assign bus.shot_count  = r_shot_cnt;
  assign bus.last_result = r_last;
  assign bus.dup_shot    = r_dup;
  assign bus.resp_error  = r_err;
  assign bus.busy        = r_busy;
  assign bus.game_over   = r_over;

endmodule

// File: tb/tb_battleship_shot_controller.sv
// Directed bench for battleship_shot_controller with hand-computed expectations.
module tb_battleship_shot_controller;

  localparam logic [4:0] B_UP    = 5'b10000;
  localparam logic [4:0] B_DOWN  = 5'b01000;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_FIRE  = 5'b00001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_shoot;

  battleship_shot_if bif ();

  battleship_shot_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count shoot-high cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (bif.shoot === 1'b1) n_shoot++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    {bif.btn_up, bif.btn_down, bif.btn_left, bif.btn_right, bif.btn_fire} = b;
    step();
    {bif.btn_up, bif.btn_down, bif.btn_left, bif.btn_right, bif.btn_fire} = 5'b0;
  endtask

  task automatic fire_shot(input logic [1:0] resp, input logic [3:0] er, input logic [3:0] ec);
    bif.btn_fire   = 1'b1;
    bif.cell_state = 2'd1;
    step();
    bif.btn_fire = 1'b0;
    check("fire_shoot", 32'(bif.shoot), 32'd1);
    check("fire_row", 32'(bif.shootRow), 32'(er));
    check("fire_col", 32'(bif.shootCol), 32'(ec));
    step();
    check("wait_shoot_low", 32'(bif.shoot), 32'd0);
    check("wait_busy", 32'(bif.busy), 32'd1);
    bif.cell_state = resp;
    step();
    bif.cell_state = 2'd0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_shoot  = 0;
    rst = 1'b1;
    {bif.btn_up, bif.btn_down, bif.btn_left, bif.btn_right, bif.btn_fire} = 5'b0;
    bif.cell_state = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_shoot", 32'(bif.shoot), 32'd0);
    check("rst_row", 32'(bif.shootRow), 32'd0);
    check("rst_col", 32'(bif.shootCol), 32'd0);
    check("rst_hits", 32'(bif.hit_count), 32'd0);
    check("rst_shots", 32'(bif.shot_count), 32'd0);
    check("rst_last", 32'(bif.last_result), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_over", 32'(bif.game_over), 32'd0);
    check("rst_err", 32'(bif.resp_error), 32'd0);

    // Row wraps 0 -> 4 -> 3 -> 2 -> 1
    press(B_UP);
    check("wrap_up_row", 32'(bif.shootRow), 32'd4);
    repeat (3) press(B_UP);
    check("up4_row", 32'(bif.shootRow), 32'd1);
    check("up4_col", 32'(bif.shootCol), 32'd0);
    check("up4_no_shoot", 32'(n_shoot), 32'd0);

    press(B_DOWN);
    repeat (3) press(B_RIGHT);
    check("cur_row", 32'(bif.shootRow), 32'd2);
    check("cur_col", 32'(bif.shootCol), 32'd3);

    fire_shot(2'd3, 4'd2, 4'd3);
    check("hit1_hits", 32'(bif.hit_count), 32'd1);
    check("hit1_shots", 32'(bif.shot_count), 32'd1);
    check("hit1_last", 32'(bif.last_result), 32'd3);
    check("hit1_busy", 32'(bif.busy), 32'd0);
    check("hit1_nshoot", 32'(n_shoot), 32'd1);

    // Same cell again is rejected
    press(B_FIRE);
    check("dup_pulse", 32'(bif.dup_shot), 32'd1);
    check("dup_no_shoot", 32'(bif.shoot), 32'd0);
    check("dup_busy", 32'(bif.busy), 32'd0);
    step();
    check("dup_one_cycle", 32'(bif.dup_shot), 32'd0);
    check("dup_hits", 32'(bif.hit_count), 32'd1);
    check("dup_shots", 32'(bif.shot_count), 32'd1);
    check("dup_nshoot", 32'(n_shoot), 32'd1);

    // Board stays EMPTY: FIRE plus four WAIT cycles, then error
    press(B_RIGHT);
    bif.cell_state = 2'd0;
    bif.btn_fire   = 1'b1;
    step();
    bif.btn_fire = 1'b0;
    check("tmo_shoot", 32'(bif.shoot), 32'd1);
    repeat (4) step();
    check("tmo_busy_before", 32'(bif.busy), 32'd1);
    check("tmo_err_before", 32'(bif.resp_error), 32'd0);
    step();
    check("tmo_err", 32'(bif.resp_error), 32'd1);
    check("tmo_busy_after", 32'(bif.busy), 32'd0);
    check("tmo_shots", 32'(bif.shot_count), 32'd1);

    // Timed-out cell is not marked, so it can be fired at again
    fire_shot(2'd2, 4'd2, 4'd4);
    check("miss_shots", 32'(bif.shot_count), 32'd2);
    check("miss_hits", 32'(bif.hit_count), 32'd1);
    check("miss_last", 32'(bif.last_result), 32'd2);
    check("miss_err_sticky", 32'(bif.resp_error), 32'd1);

    press(B_RIGHT);
    check("wrap_right_col", 32'(bif.shootCol), 32'd0);
    fire_shot(2'd3, 4'd2, 4'd0);
    press(B_DOWN);
    fire_shot(2'd3, 4'd3, 4'd0);
    press(B_DOWN);
    fire_shot(2'd3, 4'd4, 4'd0);
    check("hit4_over", 32'(bif.game_over), 32'd0);
    press(B_DOWN);
    check("wrap_down_row", 32'(bif.shootRow), 32'd0);
    fire_shot(2'd3, 4'd0, 4'd0);
    check("over_flag", 32'(bif.game_over), 32'd1);
    check("over_hits", 32'(bif.hit_count), 32'd5);
    check("over_shots", 32'(bif.shot_count), 32'd6);
    check("over_busy", 32'(bif.busy), 32'd0);
    check("over_nshoot", 32'(n_shoot), 32'd7);

    press(B_UP);
    press(B_RIGHT);
    press(B_FIRE);
    step();
    check("done_nshoot", 32'(n_shoot), 32'd7);
    check("done_row", 32'(bif.shootRow), 32'd0);
    check("done_col", 32'(bif.shootCol), 32'd0);
    check("done_sticky", 32'(bif.game_over), 32'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_over", 32'(bif.game_over), 32'd0);
    check("rst2_err", 32'(bif.resp_error), 32'd0);

    // Move priority: left beats right, up beats down
    press(B_LEFT | B_RIGHT);
    check("prio_col", 32'(bif.shootCol), 32'd4);
    press(B_UP | B_DOWN);
    check("prio_row", 32'(bif.shootRow), 32'd4);
    fire_shot(2'd3, 4'd4, 4'd4);
    check("pre_abort_hits", 32'(bif.hit_count), 32'd1);

    press(B_DOWN);
    press(B_RIGHT);
    bif.btn_fire   = 1'b1;
    bif.cell_state = 2'd1;
    step();
    bif.btn_fire = 1'b0;
    step();
    check("abort_in_wait", 32'(bif.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bif.busy), 32'd0);
    check("abort_hits", 32'(bif.hit_count), 32'd0);
    check("abort_shots", 32'(bif.shot_count), 32'd0);
    check("abort_last", 32'(bif.last_result), 32'd0);
    check("abort_row", 32'(bif.shootRow), 32'd0);
    check("abort_col", 32'(bif.shootCol), 32'd0);
    step();
    rst = 1'b0;
    bif.cell_state = 2'd0;
    step();

    fire_shot(2'd3, 4'd0, 4'd0);
    check("post_rst_dup", 32'(bif.dup_shot), 32'd0);
    check("post_rst_hits", 32'(bif.hit_count), 32'd1);
    check("post_rst_shots", 32'(bif.shot_count), 32'd1);
    check("final_nshoot", 32'(n_shoot), 32'd10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
